// File: rtl/game_pkg.sv
// Shared game-side types and constants for the round banner overlay.
// Contents:
//   banner_state_t  - banner sequencer states
//   ROUND_MIN/MAX   - legal round numbers that may be announced
//   KEY_RGB         - palette colour that is drawn as transparent
//   is_valid_round  - range check used on the round_start request
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHOW  = 2'd2,
        BLINK = 2'd3
    } banner_state_t;

    localparam logic [2:0]  ROUND_MIN = 3'd1;
    localparam logic [2:0]  ROUND_MAX = 3'd5;
    localparam logic [11:0] KEY_RGB   = 12'h8D0;

    // True when the requested round has a sprite ROM/palette pair.
    function automatic logic is_valid_round(input logic [2:0] round_num);
        return (round_num >= ROUND_MIN) && (round_num <= ROUND_MAX);
    endfunction

endpackage

// File: rtl/banner_addr_gen.sv
// Window compare and sprite address generation for the banner (combinational,
// registered by the parent in its first pipeline stage).
// Ports:
//   i_draw_x, i_draw_y : current VGA draw coordinates
//   o_in_win           : coordinate lies inside the SPR_W x SPR_H banner box
//   o_addr             : {row, column} inside the box, i.e. row*SPR_W + column
module banner_addr_gen #(
    parameter int SPR_W    = 64,
    parameter int SPR_H    = 32,
    parameter int BANNER_X = 288,
    parameter int BANNER_Y = 224
) (
    input  logic [9:0]                              i_draw_x,
    input  logic [9:0]                              i_draw_y,
    output logic                                    o_in_win,
    output logic [$clog2(SPR_W)+$clog2(SPR_H)-1:0]  o_addr
);

    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    localparam logic [9:0] X_LO = 10'(BANNER_X);
    localparam logic [9:0] X_HI = 10'(BANNER_X + SPR_W - 1);
    localparam logic [9:0] Y_LO = 10'(BANNER_Y);
    localparam logic [9:0] Y_HI = 10'(BANNER_Y + SPR_H - 1);

    logic [XB-1:0] w_dx;
    logic [YB-1:0] w_dy;

    // Sprite dimensions are powers of two, so the low bits of the offset
    // difference are the column/row and concatenation replaces the multiply.
    always_comb begin
        w_dx     = i_draw_x[XB-1:0] - X_LO[XB-1:0];
        w_dy     = i_draw_y[YB-1:0] - Y_LO[YB-1:0];
        o_addr   = {w_dy, w_dx};
        o_in_win = (i_draw_x >= X_LO) && (i_draw_x <= X_HI) &&
                   (i_draw_y >= Y_LO) && (i_draw_y <= Y_HI);
    end

endmodule

// File: rtl/round_banner_ctrl.sv
// "Round N" banner sequencer: selects the round sprite ROM/palette, generates
// the ROM address from the draw position, runs the frame-based show/blink/hide
// sequence and emits a 2-cycle pipelined pixel with an opaque flag.
// Ports:
//   Clk, Reset           : pixel clock, synchronous active-high reset
//   frame_start          : one-cycle pulse at start of vertical blank
//   round_start/round_num: request to announce a round (1..5 accepted)
//   DrawX, DrawY         : current draw coordinates
//   rom_sel              : live sprite ROM/palette pair, 0 when not busy
//   rom_addr             : sprite ROM address (held outside the banner box)
//   pal_rgb              : palette colour, arrives one cycle after rom_addr
//   red, green, blue     : banner pixel colour, zero when not opaque
//   banner_px            : current pixel is opaque banner
//   busy                 : sequence armed or displaying
module round_banner_ctrl #(
    parameter int          SPR_W        = 64,
    parameter int          SPR_H        = 32,
    parameter int          BANNER_X     = 288,
    parameter int          BANNER_Y     = 224,
    parameter int          SHOW_FRAMES  = 120,
    parameter int          BLINK_FRAMES = 64,
    parameter int          BLINK_HALF   = 8,
    parameter logic [11:0] KEY_RGB      = game_pkg::KEY_RGB
) (
    input  logic                                    Clk,
    input  logic                                    Reset,
    input  logic                                    frame_start,
    input  logic                                    round_start,
    input  logic [2:0]                              round_num,
    input  logic [9:0]                              DrawX,
    input  logic [9:0]                              DrawY,
    output logic [2:0]                              rom_sel,
    output logic [$clog2(SPR_W)+$clog2(SPR_H)-1:0]  rom_addr,
    input  logic [11:0]                             pal_rgb,
    output logic [3:0]                              red,
    output logic [3:0]                              green,
    output logic [3:0]                              blue,
    output logic                                    banner_px,
    output logic                                    busy
);

    import game_pkg::*;

    localparam int AW    = $clog2(SPR_W) + $clog2(SPR_H);
    localparam int CNT_W = $clog2((SHOW_FRAMES > BLINK_FRAMES) ? SHOW_FRAMES : BLINK_FRAMES) + 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    banner_state_t    r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n, w_cnt_inc;
    logic             r_visible, w_visible_n;
    logic [2:0]       r_round, w_round_n;
    logic             r_busy;
    logic [2:0]       r_rom_sel;
    logic             w_valid_rs;

    logic             w_in_win;
    logic [AW-1:0]    w_addr;
    logic [AW-1:0]    r_rom_addr;
    logic             r_in_win_d;
    logic             r_vis_d;

    logic             w_px;
    logic             r_px;
    logic [11:0]      r_rgb;

    banner_addr_gen #(
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .BANNER_X (BANNER_X),
        .BANNER_Y (BANNER_Y)
    ) u_addr_gen (
        .i_draw_x (DrawX),
        .i_draw_y (DrawY),
        .o_in_win (w_in_win),
        .o_addr   (w_addr)
    );

    // Next-state logic. A valid round request outranks frame_start, so a
    // coincident frame pulse is swallowed and display waits for the next one.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_visible_n = r_visible;
        w_round_n   = r_round;
        w_valid_rs  = round_start && is_valid_round(round_num);
        w_cnt_inc   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        if (w_valid_rs) begin
            w_state_n = ARMED;
            w_round_n = round_num;
            w_cnt_n   = {CNT_W{1'b0}};
        end else if (frame_start) begin
            case (r_state)
                IDLE: begin
                    w_state_n = IDLE;
                end
                ARMED: begin
                    w_state_n   = SHOW;
                    w_cnt_n     = {CNT_W{1'b0}};
                    w_visible_n = 1'b1;
                end
                SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_n = BLINK;
                        w_cnt_n   = {CNT_W{1'b0}};
                    end else begin
                        w_cnt_n = w_cnt_inc;
                    end
                end
                BLINK: begin
                    if (r_cnt == BLINK_LAST) begin
                        w_state_n   = IDLE;
                        w_cnt_n     = {CNT_W{1'b0}};
                        w_visible_n = 1'b0;
                    end else if ((32'(w_cnt_inc) % BLINK_HALF) == 32'd0) begin
                        w_cnt_n     = w_cnt_inc;
                        w_visible_n = ~r_visible;
                    end else begin
                        w_cnt_n = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_n   = IDLE;
                    w_cnt_n     = {CNT_W{1'b0}};
                    w_visible_n = 1'b0;
                end
            endcase
        end else begin
            w_state_n = r_state;
        end
    end

    // Sequencer state plus busy/rom_sel, registered from next-state values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_visible <= 1'b0;
            r_round   <= 3'd0;
            r_busy    <= 1'b0;
            r_rom_sel <= 3'd0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_visible <= w_visible_n;
            r_round   <= w_round_n;
            r_busy    <= (w_state_n != IDLE);
            r_rom_sel <= (w_state_n != IDLE) ? w_round_n : 3'd0;
        end
    end

    // Stage 0: ROM address, window flag and visibility aligned with the pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rom_addr <= {AW{1'b0}};
            r_in_win_d <= 1'b0;
            r_vis_d    <= 1'b0;
        end else begin
            r_rom_addr <= w_in_win ? w_addr : r_rom_addr;
            r_in_win_d <= w_in_win;
            r_vis_d    <= r_visible;
        end
    end

    // Opaque only inside the box, while displaying, visible, and not key colour.
    always_comb begin
        w_px = r_in_win_d && r_vis_d &&
               ((r_state == SHOW) || (r_state == BLINK)) &&
               (pal_rgb != KEY_RGB);
    end

    // Stage 1: colour output, blanked whenever the pixel is not banner.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_px  <= 1'b0;
            r_rgb <= 12'h000;
        end else begin
            r_px  <= w_px;
            r_rgb <= w_px ? pal_rgb : 12'h000;
        end
    end

    assign rom_sel   = r_rom_sel;
    assign rom_addr  = r_rom_addr;
    assign busy      = r_busy;
    assign banner_px = r_px;
    assign red       = r_rgb[11:8];
    assign green     = r_rgb[7:4];
    assign blue      = r_rgb[3:0];

endmodule

// File: tb/tb_round_banner_ctrl.sv
module tb_round_banner_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        round_start = 1'b0;
    logic [2:0]  round_num = 3'd0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [11:0] pal_rgb = 12'h000;
    logic [2:0]  rom_sel;
    logic [10:0] rom_addr;
    logic [3:0]  red, green, blue;
    logic        banner_px;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    round_banner_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .round_start (round_start),
        .round_num   (round_num),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_sel     (rom_sel),
        .rom_addr    (rom_addr),
        .pal_rgb     (pal_rgb),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .banner_px   (banner_px),
        .busy        (busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a sequence is "armed" until its first frame, then
    // "active" for SHOW+BLINK frames counted by m_fr since display began.
    bit          m_valid = 0;
    bit          m_armed = 0;
    bit          m_active = 0;
    int          m_fr = 0;
    bit          m_vis = 0;
    int          m_round = 0;
    bit          m_win_d = 0;
    bit          m_vis_d = 0;
    logic [10:0] m_addr = 11'd0;
    bit          m_px = 0;
    logic [11:0] m_rgb = 12'h000;

    always @(posedge Clk) begin
        bit win;
        if (Reset) begin
            m_valid = 1; m_armed = 0; m_active = 0; m_fr = 0; m_vis = 0;
            m_round = 0; m_win_d = 0; m_vis_d = 0; m_addr = 11'd0;
            m_px = 0; m_rgb = 12'h000;
        end else begin
            m_px  = m_win_d && m_vis_d && m_active && (pal_rgb != 12'h8D0);
            m_rgb = m_px ? pal_rgb : 12'h000;
            win = (DrawX >= 10'd288) && (DrawX <= 10'd351) &&
                  (DrawY >= 10'd224) && (DrawY <= 10'd255);
            m_vis_d = m_vis;
            m_win_d = win;
            if (win) m_addr = 11'((int'(DrawY) - 224) * 64 + (int'(DrawX) - 288));
            if (round_start && round_num >= 3'd1 && round_num <= 3'd5) begin
                m_round  = int'(round_num);
                m_armed  = 1;
                m_active = 0;
            end else if (frame_start) begin
                if (m_armed) begin
                    m_armed = 0; m_active = 1; m_fr = 0; m_vis = 1;
                end else if (m_active) begin
                    m_fr++;
                    if (m_fr >= 184) begin
                        m_active = 0; m_vis = 0;
                    end else begin
                        m_vis = (m_fr < 120) || ((((m_fr - 120) / 8) % 2) == 0);
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge Clk) begin
        #1;
        if (m_valid) begin
            chk("busy",      32'(busy),      32'(m_armed || m_active));
            chk("rom_sel",   32'(rom_sel),   (m_armed || m_active) ? 32'(m_round) : 32'd0);
            chk("rom_addr",  32'(rom_addr),  32'(m_addr));
            chk("banner_px", 32'(banner_px), 32'(m_px));
            chk("rgb",       32'({red, green, blue}), 32'(m_rgb));
        end
    end

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            @(negedge Clk);
            frame_start = 1'b0;
            repeat (6) @(negedge Clk);
        end
    endtask

    task automatic req_round(input logic [2:0] rn);
        round_num   = rn;
        round_start = 1'b1;
        @(negedge Clk);
        round_start = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic [11:0] c);
        DrawX = x; DrawY = y; pal_rgb = c;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rom_sel", 32'(rom_sel), 32'd0);
        frames(3);
        chk("idle_busy", 32'(busy), 32'd0);

        req_round(3'd3);
        chk("armed_busy", 32'(busy), 32'd1);
        chk("armed_rom_sel", 32'(rom_sel), 32'd3);
        frames(1);
        pixel(10'd288, 10'd224, 12'h000);
        chk("corner_addr", 32'(rom_addr), 32'd0);
        chk("corner_px", 32'(banner_px), 32'd1);
        chk("corner_rgb", 32'({red, green, blue}), 32'h000);
        pixel(10'd351, 10'd255, 12'hABC);
        chk("far_addr", 32'(rom_addr), 32'd2047);
        chk("far_rgb", 32'({red, green, blue}), 32'hABC);
        pixel(10'd351, 10'd255, 12'h8D0);
        chk("key_px", 32'(banner_px), 32'd0);
        pixel(10'd352, 10'd255, 12'h123);
        chk("outside_px", 32'(banner_px), 32'd0);
        chk("outside_addr_hold", 32'(rom_addr), 32'd2047);
        pixel(10'd300, 10'd230, 12'h5A5);
        chk("park_addr", 32'(rom_addr), 32'd396);

        frames(120);
        chk("blink_on_px", 32'(banner_px), 32'd1);
        frames(8);
        chk("blink_off_px", 32'(banner_px), 32'd0);
        chk("blink_busy", 32'(busy), 32'd1);
        frames(56);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_rom_sel", 32'(rom_sel), 32'd0);

        req_round(3'd0);
        chk("rn0_ignored", 32'(busy), 32'd0);
        req_round(3'd6);
        chk("rn6_ignored", 32'(busy), 32'd0);
        req_round(3'd7);
        chk("rn7_ignored", 32'(busy), 32'd0);

        req_round(3'd2);
        frames(1 + 120 + 20);
        chk("blink20_px", 32'(banner_px), 32'd1);
        req_round(3'd5);
        chk("relatch_rom_sel", 32'(rom_sel), 32'd5);
        chk("relatch_px", 32'(banner_px), 32'd0);
        frames(1);
        chk("restart_px", 32'(banner_px), 32'd1);
        frames(4);

        Reset = 1'b1; frame_start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; frame_start = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rom_sel", 32'(rom_sel), 32'd0);
        chk("rst_mid_addr", 32'(rom_addr), 32'd0);
        chk("rst_mid_px", 32'(banner_px), 32'd0);
        chk("rst_mid_rgb", 32'({red, green, blue}), 32'h000);
        repeat (3) @(negedge Clk);

        round_num = 3'd4; round_start = 1'b1; frame_start = 1'b1;
        @(negedge Clk);
        round_start = 1'b0; frame_start = 1'b0;
        repeat (4) @(negedge Clk);
        chk("coinc_busy", 32'(busy), 32'd1);
        chk("coinc_rom_sel", 32'(rom_sel), 32'd4);
        chk("coinc_not_show", 32'(banner_px), 32'd0);
        frames(1);
        chk("coinc_show_px", 32'(banner_px), 32'd1);
        repeat (3) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
